// File: rtl/fp16_dot_sched.sv
// -----------------------------------------------------------------------------
// fp16_dot_sched
//
// Sequencer for an fp16 dot product of length len. It clears the shared MAC
// accumulator, then reads one operand pair per cycle from two synchronous-read
// memories and streams each pair into the MAC. After the last pair it waits out
// the MAC pipeline latency, captures the accumulator and pulses done. This
// block does no arithmetic; fp16 values pass through unmodified.
//
// Optional feature macro: FP16_DOT_ZERO_SKIP_EN
//   When defined, mac_en is suppressed for any element whose A or B operand is
//   +/-0. The element still uses its issue slot, so timing does not change.
//   The extra output skip_cnt counts the suppressed elements of the current run.
//
// Parameters:
//   LEN_W    width of len and of the element counter (max len = 2^LEN_W-1)
//   AW       operand memory address width (AW >= LEN_W)
//   MAC_LAT  cycles from a mac_en cycle until that product shows on mac_acc
//
// Ports:
//   CLK       clock, rising edge
//   RESET     synchronous active-high reset
//   start     begin a dot product (sampled only in IDLE)
//   len       element count, latched when start is accepted
//   busy      high in every state except IDLE
//   done      one-cycle pulse; result is valid in that cycle
//   result    captured fp16 dot product, cleared on each accepted start
//   rd_en     operand memory read strobe
//   rd_addr   operand memory address (shared by both memories)
//   rd_a      memory A data, valid the cycle after rd_en
//   rd_b      memory B data, valid the cycle after rd_en
//   mac_clr   clear the MAC accumulator to +0
//   mac_en    MAC consumes mac_a/mac_b this cycle
//   mac_a     operand A to the MAC
//   mac_b     operand B to the MAC
//   mac_acc   MAC accumulator value
//   skip_cnt  (FP16_DOT_ZERO_SKIP_EN only) number of skipped elements
// -----------------------------------------------------------------------------
module fp16_dot_sched #(
   parameter int LEN_W   = 8,
   parameter int AW      = 8,
   parameter int MAC_LAT = 3
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   output logic             busy,
   output logic             done,
   output logic [15:0]      result,
   output logic             rd_en,
   output logic [AW-1:0]    rd_addr,
   input  logic [15:0]      rd_a,
   input  logic [15:0]      rd_b,
   output logic             mac_clr,
   output logic             mac_en,
   output logic [15:0]      mac_a,
   output logic [15:0]      mac_b,
   input  logic [15:0]      mac_acc
`ifdef FP16_DOT_ZERO_SKIP_EN
   ,
   output logic [LEN_W-1:0] skip_cnt
`endif
);

   localparam int DRAIN_W = (MAC_LAT < 1) ? 1 : $clog2(MAC_LAT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_ISSUE,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t             state, state_nxt;
   logic [LEN_W-1:0]   len_q, len_nxt;
   logic [LEN_W-1:0]   idx_q, idx_nxt;
   logic [DRAIN_W-1:0] drain_q, drain_nxt;
   logic [15:0]        result_q, result_nxt;
   logic               busy_q, busy_nxt;
   logic               done_q, done_nxt;
   logic               rd_en_q, rd_en_nxt;
   logic               mac_clr_q, mac_clr_nxt;
   logic               run_accept;

   // Read-data valid: memory data arrives one cycle after each rd_en.
   logic               valid_q;
   logic [15:0]        hold_a_q, hold_b_q;

   // ---------------------------------------------------------------------------
   // Next-state and next-output logic
   // ---------------------------------------------------------------------------
   // NOTE: every signal gets a default before the case so no path leaves one
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nxt   = state;
      len_nxt     = len_q;
      idx_nxt     = idx_q;
      drain_nxt   = drain_q;
      result_nxt  = result_q;
      rd_en_nxt   = 1'b0;
      mac_clr_nxt = 1'b0;
      done_nxt    = 1'b0;
      run_accept  = 1'b0;

      case (state)
         S_IDLE: begin
            if (start) begin
               run_accept = 1'b1;
               result_nxt = 16'h0000;
               if (len != '0) begin
                  len_nxt     = len;
                  idx_nxt     = '0;
                  mac_clr_nxt = 1'b1;
                  state_nxt   = S_CLEAR;
               end else begin
                  // Empty dot product: no reads, no clear, result is +0.
                  done_nxt  = 1'b1;
                  state_nxt = S_DONE;
               end
            end
         end

         S_CLEAR: begin
            rd_en_nxt = 1'b1;
            idx_nxt   = '0;
            state_nxt = S_ISSUE;
         end

         S_ISSUE: begin
            // Compare against len-1 so a full-scale len never needs idx to
            // count past the top of its range.
            if (idx_q == len_q - LEN_W'(1)) begin
               // The cycle entered next is the final mac_en cycle.
               drain_nxt = DRAIN_W'(MAC_LAT);
               state_nxt = S_DRAIN;
            end else begin
               rd_en_nxt = 1'b1;
               idx_nxt   = idx_q + LEN_W'(1);
            end
         end

         S_DRAIN: begin
            if (drain_q == '0) begin
               result_nxt = mac_acc;
               done_nxt   = 1'b1;
               state_nxt  = S_DONE;
            end else begin
               drain_nxt = drain_q - DRAIN_W'(1);
            end
         end

         S_DONE: begin
            state_nxt = S_IDLE;
         end

         default: begin
            state_nxt = S_IDLE;
         end
      endcase

      busy_nxt = (state_nxt != S_IDLE);
   end

   // ---------------------------------------------------------------------------
   // State and output registers
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state     <= S_IDLE;
         len_q     <= '0;
         idx_q     <= '0;
         drain_q   <= '0;
         result_q  <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         rd_en_q   <= 1'b0;
         mac_clr_q <= 1'b0;
         valid_q   <= 1'b0;
         hold_a_q  <= '0;
         hold_b_q  <= '0;
      end else begin
         state     <= state_nxt;
         len_q     <= len_nxt;
         idx_q     <= idx_nxt;
         drain_q   <= drain_nxt;
         result_q  <= result_nxt;
         busy_q    <= busy_nxt;
         done_q    <= done_nxt;
         rd_en_q   <= rd_en_nxt;
         mac_clr_q <= mac_clr_nxt;
         valid_q   <= rd_en_q;
         if (valid_q) begin
            hold_a_q <= rd_a;
            hold_b_q <= rd_b;
         end
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign result  = result_q;
   assign rd_en   = rd_en_q;
   assign rd_addr = AW'(idx_q);
   assign mac_clr = mac_clr_q;

   // Memory data is only present in the valid cycle, so the operands come
   // straight from the memories then and from the hold registers otherwise.
   // This keeps mac_en aligned with the data without an extra pipeline stage.
   assign mac_a = valid_q ? rd_a : hold_a_q;
   assign mac_b = valid_q ? rd_b : hold_b_q;

`ifdef FP16_DOT_ZERO_SKIP_EN
   logic             zero_op;
   logic [LEN_W-1:0] skip_q;

   // +0 and -0 differ only in the sign bit.
   assign zero_op = (rd_a[14:0] == 15'd0) || (rd_b[14:0] == 15'd0);
   assign mac_en  = valid_q && !zero_op;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         skip_q <= '0;
      end else if (run_accept) begin
         skip_q <= '0;
      end else if (valid_q && zero_op) begin
         skip_q <= skip_q + LEN_W'(1);
      end
   end

   assign skip_cnt = skip_q;
`else
   assign mac_en = valid_q;
`endif

endmodule

// File: tb/tb_fp16_dot_sched.sv
// -----------------------------------------------------------------------------
// tb_fp16_dot_sched
//
// Directed bench for fp16_dot_sched. Surrounds the DUT with two synchronous
// read memories and a behavioural fp16 MAC (three-cycle latency), runs a linear
// sequence of dot products and compares the observed timing and results with
// hand-computed values.
// -----------------------------------------------------------------------------
module tb_fp16_dot_sched;

   localparam int LEN_W   = 8;
   localparam int AW      = 8;
   localparam int MAC_LAT = 3;

   logic             CLK;
   logic             RESET;
   logic             start;
   logic [LEN_W-1:0] len;
   logic             busy;
   logic             done;
   logic [15:0]      result;
   logic             rd_en;
   logic [AW-1:0]    rd_addr;
   logic [15:0]      rd_a;
   logic [15:0]      rd_b;
   logic             mac_clr;
   logic             mac_en;
   logic [15:0]      mac_a;
   logic [15:0]      mac_b;
   logic [15:0]      mac_acc;
`ifdef FP16_DOT_ZERO_SKIP_EN
   logic [LEN_W-1:0] skip_cnt;
`endif

   fp16_dot_sched #(
      .LEN_W   (LEN_W),
      .AW      (AW),
      .MAC_LAT (MAC_LAT)
   ) dut (
      .CLK      (CLK),
      .RESET    (RESET),
      .start    (start),
      .len      (len),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .rd_en    (rd_en),
      .rd_addr  (rd_addr),
      .rd_a     (rd_a),
      .rd_b     (rd_b),
      .mac_clr  (mac_clr),
      .mac_en   (mac_en),
      .mac_a    (mac_a),
      .mac_b    (mac_b),
      .mac_acc  (mac_acc)
`ifdef FP16_DOT_ZERO_SKIP_EN
      ,
      .skip_cnt (skip_cnt)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // ---------------------------------------------------------------------------
   // Operand memories: synchronous read, data the cycle after rd_en
   // ---------------------------------------------------------------------------
   logic [15:0] mem_a [0:255];
   logic [15:0] mem_b [0:255];

   initial begin
      rd_a = 16'h0000;
      rd_b = 16'h0000;
   end

   always @(posedge CLK) begin
      if (rd_en) begin
         rd_a <= mem_a[rd_addr];
         rd_b <= mem_b[rd_addr];
      end
   end

   // ---------------------------------------------------------------------------
   // Behavioural fp16 MAC: a mac_en cycle is visible on mac_acc three cycles on
   // ---------------------------------------------------------------------------
   function automatic real pow2(input int e);
      real r;
      r = 1.0;
      if (e >= 0) begin
         for (int i = 0; i < e; i++) r = r * 2.0;
      end else begin
         for (int i = 0; i < -e; i++) r = r / 2.0;
      end
      return r;
   endfunction

   function automatic real h2r(input logic [15:0] h);
      real v;
      int  e;
      e = int'(h[14:10]);
      if (e == 0) v = real'(h[9:0]) * pow2(-24);
      else        v = (1.0 + real'(h[9:0]) / 1024.0) * pow2(e - 15);
      return h[15] ? -v : v;
   endfunction

   function automatic logic [15:0] r2h(input real v);
      logic s;
      real  a;
      int   e;
      int   m;
      s = (v < 0.0);
      a = s ? -v : v;
      if (a == 0.0) return {s, 15'd0};
      e = 15;
      while (a >= 2.0) begin a = a / 2.0; e++; end
      while (a < 1.0)  begin a = a * 2.0; e--; end
      m = int'((a - 1.0) * 1024.0);
      if (m == 1024) begin m = 0; e++; end
      return {s, 5'(e), 10'(m)};
   endfunction

   logic mp1_v, mp2_v;
   real  mp1_p, mp2_p, acc_r;

   initial begin
      mac_acc = 16'h0000;
      mp1_v   = 1'b0;
      mp2_v   = 1'b0;
      mp1_p   = 0.0;
      mp2_p   = 0.0;
      acc_r   = 0.0;
   end

   always @(posedge CLK) begin
      if (RESET || mac_clr) begin
         mp1_v = 1'b0;
         mp2_v = 1'b0;
         acc_r = 0.0;
      end else begin
         if (mp2_v) acc_r = acc_r + mp2_p;
         mp2_v = mp1_v;
         mp2_p = mp1_p;
         mp1_v = mac_en;
         mp1_p = h2r(mac_a) * h2r(mac_b);
      end
      mac_acc <= r2h(acc_r);
   end

   // ---------------------------------------------------------------------------
   // Checking
   // ---------------------------------------------------------------------------
   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Observations of one run, cycle k = the cycle sampled at edge k, with
   // start sampled at edge 0.
   int          clr_cnt, clr_cyc;
   int          rd_cnt, rd_first, rd_last, addr_bad, addr_max;
   int          mac_cnt, mac_first, mac_last;
   int          done_cnt, done_cyc;
   logic [15:0] res_at_done, first_mac_a, first_mac_b, mac_a_at_done;
   logic        busy_after;
   logic [31:0] rst_snapshot;
   int          skip_at_done;

   task automatic go(input logic [LEN_W-1:0] l);
      @(negedge CLK);
      start = 1'b1;
      len   = l;
   endtask

   // Watch one run. Optionally pulse start with inj_len in cycle inj_cyc, or
   // assert RESET in cycle rst_cyc. Returns one cycle after done, or when the
   // cycle budget runs out.
   task automatic watch(input int budget, input int inj_cyc,
                        input logic [LEN_W-1:0] inj_len, input int rst_cyc);
      clr_cnt = 0;  clr_cyc = -1;
      rd_cnt = 0;   rd_first = -1; rd_last = -1; addr_bad = 0; addr_max = -1;
      mac_cnt = 0;  mac_first = -1; mac_last = -1;
      done_cnt = 0; done_cyc = -1;
      res_at_done = 16'hxxxx; mac_a_at_done = 16'hxxxx;
      first_mac_a = 16'hxxxx; first_mac_b = 16'hxxxx;
      busy_after = 1'bx; rst_snapshot = 32'hxxxx_xxxx; skip_at_done = -1;
      for (int k = 1; k <= budget; k++) begin
         @(negedge CLK);
         if (k == 1) start = 1'b0;
         if (done_cyc >= 0 && k == done_cyc + 1) begin
            busy_after = busy;
            break;
         end
         if (mac_clr) begin clr_cnt++; clr_cyc = k; end
         if (rd_en) begin
            if (rd_first < 0) rd_first = k;
            if (int'(rd_addr) != k - rd_first) addr_bad++;
            if (int'(rd_addr) > addr_max) addr_max = int'(rd_addr);
            rd_last = k;
            rd_cnt++;
         end
         if (mac_en) begin
            if (mac_first < 0) begin
               mac_first   = k;
               first_mac_a = mac_a;
               first_mac_b = mac_b;
            end
            mac_last = k;
            mac_cnt++;
         end
         if (done) begin
            done_cnt++;
            done_cyc      = k;
            res_at_done   = result;
            mac_a_at_done = mac_a;
`ifdef FP16_DOT_ZERO_SKIP_EN
            skip_at_done  = int'(skip_cnt);
`endif
         end
         if (k == rst_cyc + 1) begin
            rst_snapshot = {busy, done, rd_en, mac_clr, mac_en, 27'd0} |
                           32'(rd_addr) | 32'(mac_a) | 32'(mac_b) | 32'(result);
            RESET = 1'b0;
         end
         if (k == rst_cyc) RESET = 1'b1;
         if (k == inj_cyc) begin start = 1'b1; len = inj_len; end
         if (k == inj_cyc + 1) start = 1'b0;
      end
   endtask

   initial begin
      RESET = 1'b1;
      start = 1'b0;
      len   = '0;
      for (int i = 0; i < 256; i++) begin
         mem_a[i] = 16'h0000;
         mem_b[i] = 16'h0000;
      end

      // Reset state
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk("rst_busy",    32'(busy),    32'd0);
      chk("rst_done",    32'(done),    32'd0);
      chk("rst_rd_en",   32'(rd_en),   32'd0);
      chk("rst_mac_clr", 32'(mac_clr), 32'd0);
      chk("rst_mac_en",  32'(mac_en),  32'd0);
      chk("rst_rd_addr", 32'(rd_addr), 32'd0);
      chk("rst_mac_a",   32'(mac_a),   32'd0);
      chk("rst_result",  32'(result),  32'd0);
      RESET = 1'b0;
      repeat (2) @(negedge CLK);

      // Basic: 1.0*2.0 + 3.0*0.5 = 3.5
      mem_a[0] = 16'h3C00; mem_b[0] = 16'h4000;
      mem_a[1] = 16'h4200; mem_b[1] = 16'h3800;
      go(8'd2);
      watch(40, -10, '0, -10);
      chk("basic_clr_cyc",   32'(clr_cyc),   32'd1);
      chk("basic_clr_cnt",   32'(clr_cnt),   32'd1);
      chk("basic_rd_first",  32'(rd_first),  32'd2);
      chk("basic_rd_last",   32'(rd_last),   32'd3);
      chk("basic_addr_seq",  32'(addr_bad),  32'd0);
      chk("basic_mac_first", 32'(mac_first), 32'd3);
      chk("basic_mac_last",  32'(mac_last),  32'd4);
      chk("basic_mac_cnt",   32'(mac_cnt),   32'd2);
      chk("basic_mac_a0",    32'(first_mac_a), 32'h3C00);
      chk("basic_mac_b0",    32'(first_mac_b), 32'h4000);
      chk("basic_mac_a_hold", 32'(mac_a_at_done), 32'h4200);
      chk("basic_done_cyc",  32'(done_cyc),  32'd8);
      chk("basic_done_cnt",  32'(done_cnt),  32'd1);
      chk("basic_result",    32'(res_at_done), 32'h4300);
      chk("basic_busy_after", 32'(busy_after), 32'd0);

      // len = 0: immediate done, nothing issued
      go(8'd0);
      watch(10, -10, '0, -10);
      chk("len0_done_cyc", 32'(done_cyc),    32'd1);
      chk("len0_result",   32'(res_at_done), 32'h0000);
      chk("len0_rd_cnt",   32'(rd_cnt),      32'd0);
      chk("len0_clr_cnt",  32'(clr_cnt),     32'd0);
      chk("len0_mac_cnt",  32'(mac_cnt),     32'd0);
      chk("len0_busy_after", 32'(busy_after), 32'd0);

      // start with len=5 during ISSUE of a len=3 run is ignored: 3 x (2*2) = 12
      for (int i = 0; i < 5; i++) begin
         mem_a[i] = 16'h4000;
         mem_b[i] = 16'h4000;
      end
      go(8'd3);
      watch(40, 3, 8'd5, -10);
      chk("ign_rd_cnt",   32'(rd_cnt),      32'd3);
      chk("ign_done_cyc", 32'(done_cyc),    32'd9);
      chk("ign_done_cnt", 32'(done_cnt),    32'd1);
      chk("ign_result",   32'(res_at_done), 32'h4A00);
      chk("ign_busy_after", 32'(busy_after), 32'd0);

      // Maximum length: 255 x (1.0*1.0) = 255.0
      for (int i = 0; i < 256; i++) begin
         mem_a[i] = 16'h3C00;
         mem_b[i] = 16'h3C00;
      end
      go(8'd255);
      watch(300, -10, '0, -10);
      chk("max_rd_cnt",   32'(rd_cnt),      32'd255);
      chk("max_rd_first", 32'(rd_first),    32'd2);
      chk("max_rd_last",  32'(rd_last),     32'd256);
      chk("max_addr_seq", 32'(addr_bad),    32'd0);
      chk("max_addr_top", 32'(addr_max),    32'd254);
      chk("max_mac_cnt",  32'(mac_cnt),     32'd255);
      chk("max_done_cyc", 32'(done_cyc),    32'd261);
      chk("max_result",   32'(res_at_done), 32'h5BF8);

      // RESET during DRAIN of a len=4 run (DRAIN is cycles 6..9)
      go(8'd4);
      watch(20, -10, '0, 7);
      chk("rstd_outputs",  rst_snapshot,     32'd0);
      chk("rstd_done_cnt", 32'(done_cnt),    32'd0);

      // Fresh run after the abort
      mem_a[0] = 16'h3C00; mem_b[0] = 16'h4000;
      mem_a[1] = 16'h4200; mem_b[1] = 16'h3800;
      go(8'd2);
      watch(40, -10, '0, -10);
      chk("fresh_clr_cyc",  32'(clr_cyc),     32'd1);
      chk("fresh_done_cyc", 32'(done_cyc),    32'd8);
      chk("fresh_result",   32'(res_at_done), 32'h4300);

      // Zero operands: 1*2 + 0*3 + (-0)*1 + 2*2 = 6.0
      mem_a[0] = 16'h3C00; mem_b[0] = 16'h4000;
      mem_a[1] = 16'h0000; mem_b[1] = 16'h4200;
      mem_a[2] = 16'h8000; mem_b[2] = 16'h3C00;
      mem_a[3] = 16'h4000; mem_b[3] = 16'h4000;
      go(8'd4);
      watch(40, -10, '0, -10);
      chk("zs_rd_cnt",   32'(rd_cnt),      32'd4);
      chk("zs_done_cyc", 32'(done_cyc),    32'd10);
      chk("zs_result",   32'(res_at_done), 32'h4600);
      chk("zs_mac_first", 32'(mac_first),  32'd3);
`ifdef FP16_DOT_ZERO_SKIP_EN
      chk("zs_mac_cnt",  32'(mac_cnt),      32'd2);
      chk("zs_mac_last", 32'(mac_last),     32'd6);
      chk("zs_skip_cnt", 32'(skip_at_done), 32'd2);
`else
      chk("zs_mac_cnt",  32'(mac_cnt),      32'd4);
      chk("zs_mac_last", 32'(mac_last),     32'd6);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
